// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-port data memory.
// Each transaction is latched in IDLE, driven for one XFER cycle, and acknowledged in RESP.
module dm_arbiter #(
  parameter int AWIDTH  = 32,
  parameter int ALENGTH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [AWIDTH-1:0] a_addr,
  input  logic [AWIDTH-1:0] a_wdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [AWIDTH-1:0] b_addr,
  input  logic [AWIDTH-1:0] b_wdata,
  output logic              b_ack,
  output logic [AWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              dm_we,
  output logic [AWIDTH-1:0] dm_addr,
  output logic [AWIDTH-1:0] dm_wdata,
  input  logic [AWIDTH-1:0] dm_rdata
);

  // Handshake: a requester raises req with we/addr/wdata stable and holds it until
  // its ack pulses for one cycle; it drops req the cycle after. Req is only sampled
  // in IDLE, so a pending req simply waits while busy and is never stalled combinationally.

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  localparam logic [AWIDTH-1:0] ALEN = AWIDTH'(ALENGTH);

  state_t state, state_nxt;
  logic   cur_grant;   // 0 = port A, 1 = port B
  logic   last_grant;
  logic   lat_we;
  logic   grant_b;
  logic   in_range;

  // dm_addr/dm_wdata double as the latched transaction registers.
  assign in_range = (dm_addr < ALEN);

  always_comb begin
    state_nxt = state;
    grant_b   = 1'b0;
    case (state)
      IDLE: begin
        grant_b = b_req & (~a_req | ~last_grant);
        if (a_req | b_req) state_nxt = XFER;
      end
      XFER:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_grant  <= 1'b0;
      last_grant <= 1'b1;
      lat_we     <= 1'b0;
      dm_addr    <= '0;
      dm_wdata   <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (a_req | b_req)) begin
        cur_grant <= grant_b;
        lat_we    <= grant_b ? b_we    : a_we;
        dm_addr   <= grant_b ? b_addr  : a_addr;
        dm_wdata  <= grant_b ? b_wdata : a_wdata;
      end
      if (state == XFER) begin
        rsp_rdata <= (!lat_we && in_range) ? dm_rdata : '0;
        rsp_err   <= ~in_range;
      end
      if (state == RESP) last_grant <= cur_grant;
    end
  end

  // rst gates the strobe directly so an aborted XFER never reaches the memory.
  assign dm_we = (state == XFER) & lat_we & in_range & ~rst;
  assign a_ack = (state == RESP) & ~cur_grant;
  assign b_ack = (state == RESP) &  cur_grant;
  assign busy  = (state != IDLE);

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory (Datmem: WE2, Addr, WriDat, ReaDat).
- Port A is the CPU load/store path; port B is the loader/debug path.
- Each transaction is latched, driven to memory for exactly one cycle, and acknowledged with registered read data.
- Round-robin fairness, out-of-range address protection, and safe abort on reset.

Parameters:
- AWIDTH, 32, data and address width (matches Datmem).
- ALENGTH, 128, number of memory words; valid word addresses are 0..ALENGTH-1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  port A request; held high until a_ack.
- a_we  in  1  port A: 1 = write, 0 = read; stable while a_req.
- a_addr  in  AWIDTH  port A word address; stable while a_req.
- a_wdata  in  AWIDTH  port A write data; stable while a_req.
- a_ack  out  1  port A one-cycle completion pulse.
- b_req, b_we, b_addr, b_wdata, b_ack  same as port A, for port B.
- rsp_rdata  out  AWIDTH  read data; valid when a_ack or b_ack is high.
- rsp_err  out  1  address-out-of-range flag; valid with ack.
- busy  out  1  high whenever state != IDLE.
- dm_we  out  1  to Datmem WE2.
- dm_addr  out  AWIDTH  to Datmem Addr.
- dm_wdata  out  AWIDTH  to Datmem WriDat.
- dm_rdata  in  AWIDTH  from Datmem ReaDat (combinational read).

Behaviour:
- Reset values:
  - state = IDLE; a_ack = b_ack = 0; rsp_rdata = 0; rsp_err = 0.
  - dm_we = 0; dm_addr = 0; dm_wdata = 0; busy = 0.
  - last_grant = B, so A wins the first tie.
- FSM states are IDLE, XFER, RESP; every transaction passes through all three.
- IDLE:
  - If any req is high, choose a winner:
    - Only one requester: grant it.
    - Both requesting: grant the port not equal to last_grant.
  - Latch the winner's we/addr/wdata into internal registers, record the winner in cur_grant, then go to XFER.
  - No req: stay in IDLE.
- XFER (exactly one cycle):
  - dm_addr and dm_wdata come from the latched registers.
  - dm_we = latched_we AND in_range AND NOT rst. The memory write occurs at the end of this cycle.
  - in_range means latched_addr < ALENGTH, as a full AWIDTH unsigned compare.
  - At the closing edge:
    - rsp_rdata <= (read AND in_range) ? dm_rdata : 0. Writes also load 0.
    - rsp_err <= NOT in_range.
  - Next state: RESP.
- RESP (exactly one cycle):
  - Assert the ack of cur_grant only; the other ack stays 0.
  - rsp_rdata and rsp_err are held.
  - Update last_grant <= cur_grant, then go to IDLE.
- Outside XFER: dm_we = 0; dm_addr and dm_wdata hold their last driven value.
- Latency and throughput:
  - A req sampled at edge k gives ack high in the cycle after edge k+1 (ack seen at edge k+2).
  - Maximum throughput is one transaction per 3 cycles.
- Requester rule:
  - Drop req in the cycle after seeing ack.
  - Because IDLE samples req no earlier than edge k+3, the same request is never issued twice.
- Requests arriving while busy are not sampled. They stay pending (req held) until the next IDLE cycle.
- Requester ports are never stalled combinationally.
- Out-of-range access:
  - No memory write; rsp_rdata = 0; rsp_err = 1 for that ack only.
  - Arbitration proceeds normally.
- Reset mid-operation:
  - rst in XFER suppresses dm_we in that same cycle, so memory is unmodified.
  - At the edge, state goes to IDLE and all outputs take their reset values.
  - No ack is ever issued for an aborted transaction; the requester must re-request.
- Alternation under contention: with both reqs continuously high, grants go A, B, A, B, and so on. No starvation.
- No combinational path from any req to dm_we or ack.

Test Plan:
- Reset, then A writes 0x00006000 to addr 127 → dm_we high for exactly one cycle with dm_addr = 127; a_ack pulses 2 edges after req is sampled; rsp_err = 0.
- B reads addr 127 after the previous write → b_ack pulse with rsp_rdata = 0x00006000; a_ack stays 0; dm_we stays 0 throughout.
- A and B requested on the same edge (A write 0x11 to addr 5, B write 0x22 to addr 5) → A granted first, B second. A read of addr 5 then returns 0x22. Continuous requests show A,B,A,B ack order, with 3-cycle spacing.
- A writes 0xDEADBEEF to addr 128 → dm_we never asserted; a_ack with rsp_err = 1 and rsp_rdata = 0. A read of addr 0x80000000 gives the same result (err = 1).
- rst asserted during the XFER cycle of A write 0x55 to addr 10 → no write: a later read of addr 10 returns its prior value; no a_ack; busy = 0 after the reset edge.
- B req held high while an A transaction is in progress → B is not sampled until IDLE; b_ack arrives 3 cycles after a_ack.
